// File: rtl/scm_mbist_pkg.sv
// rtl/scm_mbist_pkg.sv - state, element and background definitions for the SCM March C- BIST
package scm_mbist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_LAST = 3'd5;

  // Bit e of each mask describes march element e (E0..E5); bits 6-7 are spare.
  localparam logic [7:0] ELEM_DOWN = 8'b0001_1000;
  localparam logic [7:0] ELEM_RD   = 8'b0011_1110;
  localparam logic [7:0] ELEM_RINV = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR   = 8'b0001_1111;
  localparam logic [7:0] ELEM_WINV = 8'b0000_1010;

  localparam logic [63:0] CKBD_EVEN = {32{2'b01}};
  localparam logic [63:0] CKBD_ODD  = {32{2'b10}};

endpackage

// File: rtl/scm_mbist_cmp.sv
// rtl/scm_mbist_cmp.sv - read-latency aligned expected-data pipe and DOUT comparator
module scm_mbist_cmp
  import scm_mbist_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  elem_t         in_elem,
  input  logic [DW-1:0] in_exp,
  input  logic [DW-1:0] dout,
  output logic          mismatch,
  output logic [AW-1:0] mis_addr,
  output elem_t         mis_elem
);

  logic [RD_LAT-1:0] valid_q;
  logic [AW-1:0]     addr_q [RD_LAT];
  elem_t             elem_q [RD_LAT];
  logic [DW-1:0]     exp_q  [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
        elem_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid && !flush;
      addr_q[0]  <= in_addr;
      elem_q[0]  <= in_elem;
      exp_q[0]   <= in_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1] && !flush;
        addr_q[i]  <= addr_q[i-1];
        elem_q[i]  <= elem_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
    end
  end

  // The last stage lines up with the cycle in which DOUT carries that read.
  assign mismatch = valid_q[RD_LAT-1] && (dout != exp_q[RD_LAT-1]);
  assign mis_addr = addr_q[RD_LAT-1];
  assign mis_elem = elem_q[RD_LAT-1];

endmodule

// File: rtl/scm_mbist_ctrl.sv
// rtl/scm_mbist_ctrl.sv - March C- BIST controller driving an SCM write/read port pair
// Build option SCM_MBIST_CKBD_EN: per-address checkerboard background instead of all-zeros.
module scm_mbist_ctrl
  import scm_mbist_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic [AW-1:0] FAIL_ADDR,
  output logic [2:0]    FAIL_ELEM,
  output logic [AW-1:0] WADDR,
  output logic          WE,
  output logic [DW-1:0] DIN,
  output logic [AW-1:0] RADDR,
  output logic          RE,
  output logic          SE,
  input  logic [DW-1:0] DOUT
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  elem_t         elem, ld_elem;
  logic [AW-1:0] addr, ld_addr, end_addr;
  logic          phase, ld_phase, ld_rd, last_op, issue;
  logic [1:0]    drain_cnt;
  logic [DW-1:0] wr_base, rd_base, ld_din, rd_exp;
  logic          mismatch;
  logic [AW-1:0] mis_addr;
  elem_t         mis_elem;

  assign SE       = 1'b0;
  assign end_addr = ELEM_DOWN[elem] ? '0 : LAST_ADDR;

  // Next operation to put on the ports; outside RUN this is E0's first write.
  always_comb begin
    ld_elem  = '0;
    ld_addr  = '0;
    ld_phase = 1'b0;
    last_op  = 1'b0;
    if (state == ST_RUN) begin
      if (ELEM_RD[elem] && ELEM_WR[elem] && !phase) begin
        ld_elem  = elem;
        ld_addr  = addr;
        ld_phase = 1'b1;
      end else if (addr == end_addr) begin
        last_op = (elem == ELEM_LAST);
        ld_elem = elem + 3'd1;
        ld_addr = ELEM_DOWN[ld_elem] ? LAST_ADDR : '0;
      end else begin
        ld_elem = elem;
        ld_addr = ELEM_DOWN[elem] ? addr - AW'(1) : addr + AW'(1);
      end
    end
  end

  assign ld_rd = ELEM_RD[ld_elem] && !ld_phase;
  assign issue = ((state == ST_IDLE || state == ST_DONE) && START) ||
                 (state == ST_RUN && !mismatch && !last_op);

`ifdef SCM_MBIST_CKBD_EN
  assign wr_base = ld_addr[0] ? CKBD_ODD[DW-1:0] : CKBD_EVEN[DW-1:0];
  assign rd_base = RADDR[0]   ? CKBD_ODD[DW-1:0] : CKBD_EVEN[DW-1:0];
`else
  assign wr_base = '0;
  assign rd_base = '0;
`endif

  assign ld_din = wr_base ^ {DW{ELEM_WINV[ld_elem]}};
  assign rd_exp = rd_base ^ {DW{ELEM_RINV[elem]}};

  scm_mbist_cmp #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk      (CLK),
    .rst_n    (RSTN),
    .flush    (mismatch),
    .in_valid (RE),
    .in_addr  (RADDR),
    .in_elem  (elem),
    .in_exp   (rd_exp),
    .dout     (DOUT),
    .mismatch (mismatch),
    .mis_addr (mis_addr),
    .mis_elem (mis_elem)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      elem      <= '0;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      WADDR     <= '0;
      WE        <= 1'b0;
      DIN       <= '0;
      RADDR     <= '0;
      RE        <= 1'b0;
    end else begin
      if (issue) begin
        elem  <= ld_elem;
        addr  <= ld_addr;
        phase <= ld_phase;
        WE    <= !ld_rd;
        RE    <= ld_rd;
        if (ld_rd) begin
          RADDR <= ld_addr;
        end else begin
          WADDR <= ld_addr;
          DIN   <= ld_din;
        end
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state     <= ST_RUN;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_ELEM <= '0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (mismatch) begin
            state     <= ST_DONE;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            FAIL      <= 1'b1;
            FAIL_ADDR <= mis_addr;
            FAIL_ELEM <= mis_elem;
            WE        <= 1'b0;
            RE        <= 1'b0;
          end else if (state == ST_RUN) begin
            if (last_op) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
              WE        <= 1'b0;
              RE        <= 1'b0;
            end
          end else if (drain_cnt == 2'(RD_LAT - 1)) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/scm_mbist_ctrl.md
Name: scm_mbist_ctrl

Overview:
- March C- built-in self-test controller; the initiator side of the SCM port set (WADDR/WE/DIN, RADDR/RE, DOUT, SE).
- Sits beside an SCM instance. Drives write and read ports, checks DOUT against expected background, reports pass/fail and first failing address and element.
- Runs once per START. Idle otherwise; memory ports are quiescent when idle.

Parameters:
- AW, 8, address width.
- DW, 16, data width.
- DEPTH, 256, words tested (addresses 0..DEPTH-1, DEPTH <= 2**AW).
- RD_LAT, 1, cycles from RE/RADDR driven to DOUT valid (1..3).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  async active-low reset.
- START  in  1  start request, sampled in IDLE/DONE.
- BUSY  out  1  test in progress.
- DONE  out  1  test finished, held until next START.
- FAIL  out  1  mismatch detected, valid when DONE.
- FAIL_ADDR  out  AW  address of first mismatch.
- FAIL_ELEM  out  3  march element (0..5) of first mismatch.
- WADDR  out  AW  SCM write address.
- WE  out  1  SCM write enable.
- DIN  out  DW  SCM write data.
- RADDR  out  AW  SCM read address.
- RE  out  1  SCM read enable.
- SE  out  1  SCM scan enable, constant 0.
- DOUT  in  DW  SCM read data.

Behaviour:
- Reset (async, RSTN=0): state IDLE. BUSY, DONE, FAIL, WE and RE are 0. FAIL_ADDR, FAIL_ELEM, WADDR, RADDR and DIN are 0. The compare pipe is flushed.
- All memory-side outputs are registered.
- March C- elements, B = background:
  - E0 up(wB)
  - E1 up(rB, w~B)
  - E2 up(r~B, wB)
  - E3 down(rB, w~B)
  - E4 down(r~B, wB)
  - E5 up(rB)
  - Up = 0 to DEPTH-1; down = DEPTH-1 to 0.
  - B = all-zeros, ~B = all-ones.
- Timing per address:
  - E0: 1 cycle (WE=1).
  - E5: 1 cycle (RE=1).
  - E1-E4: 2 cycles. RE=1 with RADDR=a, then WE=1 with WADDR=a.
  - RE and WE are never both high in one cycle.
- States:
  - IDLE: START moves to RUN. Clears DONE, FAIL, FAIL_ADDR, FAIL_ELEM.
  - RUN: element/address/phase sequencing. After the last E5 read, moves to DRAIN.
  - DRAIN: waits RD_LAT cycles for outstanding compares, then moves to DONE.
  - DONE: DONE=1, BUSY=0. START restarts the test, same action as from IDLE.
- BUSY=1 in RUN and DRAIN. START is ignored while BUSY.
- Compare:
  - Each read pushes {valid, addr, elem, expected} into an RD_LAT-deep pipe.
  - At pipe exit, DOUT != expected is a mismatch.
- On first mismatch:
  - FAIL=1, and FAIL_ADDR/FAIL_ELEM are captured from the pipe entry.
  - The test aborts: WE and RE are 0 from the next cycle.
  - Remaining pipe entries are discarded, and the state goes to DONE the cycle after.
  - Later mismatches are never recorded.
- Latency: the first WE is high in the cycle after START is sampled. Fault-free run gives 10*DEPTH RUN cycles plus RD_LAT DRAIN cycles, then DONE.
- Address counter wraps only at element boundaries. Down elements start at DEPTH-1; no out-of-range address is ever driven.
- Reset mid-test: immediate async return to the reset values above. No partial write is driven after RSTN falls.
- SE tied 0 in every state.

Optional Feature:
- Macro SCM_MBIST_CKBD_EN.
- Defined: background B is per-address checkerboard, 0x5555.. for even addresses and 0xAAAA.. for odd addresses. ~B is its bitwise inverse. Expected values in the compare pipe follow the same rule.
- Undefined: B is all-zeros only, and no checkerboard logic is present.

Decomposition:
- Shared package scm_mbist_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - element index type (3 bits).
  - march table constants per element: direction, has_read, read_inv, has_write, write_inv.
  - checkerboard pattern constants.
- Sub-module scm_mbist_cmp: RD_LAT-deep valid/addr/elem/expected pipe plus comparator. Outputs mismatch, mis_addr, mis_elem. Has a flush input.

Test Plan:
- Fault-free behavioural SCM (DEPTH=256, RD_LAT=1), START pulse → DONE after 2561 cycles post-start, FAIL=0, BUSY low with DONE.
- Stuck-at-1 on bit 3 at 0x2A → FAIL=1, FAIL_ADDR=0x2A, FAIL_ELEM=1. No WE/RE after the mismatch cycle+1.
- Address alias (write to 0x10 also writes 0x11) → FAIL=1, FAIL_ADDR=0x11, FAIL_ELEM=1.
- RSTN low at cycle 700 → all outputs 0 same cycle. After release, START runs a clean full pass with FAIL=0.
- START pulsed repeatedly while BUSY → no restart, same completion cycle. RD_LAT=3 rerun → DONE 2 cycles later than RD_LAT=1.
- SCM_MBIST_CKBD_EN defined → E0 writes 0x5555 to address 0 and 0xAAAA to address 1. E1 writes 0xAAAA to address 0. Fault-free run passes.
